// File: rtl/ltc2174_train_pkg.sv
// Shared types and constants for the LTC2174 link-training sequencer.
package ltc2174_train_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StCfgTp,
    StWaitTp,
    StBitslip,
    StWaitBs,
    StCheck,
    StCfgAlt,
    StWaitAlt,
    StCheckAlt,
    StCfgNorm,
    StWaitNorm,
    StDone,
    StFail
  } train_state_e;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_CFG_TO  = 3'd1;
  localparam logic [2:0] FC_RDBK    = 3'd2;
  localparam logic [2:0] FC_BITSLIP = 3'd3;
  localparam logic [2:0] FC_PATTERN = 3'd4;

  localparam logic [13:0] DefTestPattern = 14'h2A5C;

  // The deserializer presents the 14-bit sample left-justified in a 16-bit word.
  function automatic logic [15:0] pattern_word(input logic [13:0] tp);
    return {tp, 2'b00};
  endfunction

endpackage

// File: rtl/train_word_checker.sv
// Four-channel pattern comparator with a consecutive-match counter; pass once
// CHECK_LEN back-to-back matching cycles have been seen since the last clear.
module train_word_checker #(
  parameter int unsigned CHECK_LEN = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [3:0][15:0] words_i,
  input  logic [15:0]      exp_i,
  input  logic             clr_i,
  output logic             pass_o
);

  localparam int unsigned CntW = $clog2(CHECK_LEN + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            all_match;

  always_comb begin
    all_match = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (words_i[i] != exp_i) all_match = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !all_match) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(CHECK_LEN)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign pass_o = (cnt_q == CntW'(CHECK_LEN));

endmodule

// File: rtl/ltc2174_train_ctrl.sv
// Link-training sequencer for one LTC2174 bank: test pattern via SPI, bitslip, pattern
// check with retries, then back to normal output. Define TRAIN_ALTPAT_EN for a second
// check against the inverted pattern.
module ltc2174_train_ctrl
  import ltc2174_train_pkg::*;
#(
  parameter logic [13:0] TEST_PATTERN = DefTestPattern,
  parameter int unsigned CHECK_LEN    = 64,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned TIMEOUT_W    = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        train_start_i,
  output logic        cfg_outtest_o,
  output logic [13:0] cfg_testpattern_o,
  output logic        cfg_start_o,
  input  logic        cfg_done_i,
  input  logic        cfg_outtest_rdbk_i,
  output logic        bs_start_o,
  input  logic        bs_cmp_i,
  input  logic        bs_err_i,
  input  logic [15:0] adc1_i,
  input  logic [15:0] adc2_i,
  input  logic [15:0] adc3_i,
  input  logic [15:0] adc4_i,
  output logic        busy_o,
  output logic        link_ok_o,
  output logic        fail_o,
  output logic [2:0]  fail_code_o,
  output logic [1:0]  retry_cnt_o
);

  train_state_e         state_q, state_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 start_q;
  logic                 outtest_q, outtest_d;
  logic [13:0]          tp_q, tp_d;
  logic                 cfg_start_q, cfg_start_d;
  logic                 bs_start_q, bs_start_d;
  logic                 busy_q, busy_d;
  logic                 link_ok_q, link_ok_d;
  logic                 fail_q, fail_d;
  logic [2:0]           fail_code_q, fail_code_d;
  logic [1:0]           retry_q, retry_d;

  logic       start_edge, timeout, pass, chk_clr;
  logic       attempt_fail, go_fail;
  logic [2:0] fail_code_n;
  logic [15:0] exp_word;

  assign start_edge = train_start_i & ~start_q;
  assign timeout    = &tmo_q;
  assign chk_clr    = !(state_q == StCheck || state_q == StCheckAlt);

`ifdef TRAIN_ALTPAT_EN
  assign exp_word = (state_q == StCheckAlt) ? pattern_word(~TEST_PATTERN)
                                            : pattern_word(TEST_PATTERN);
`else
  assign exp_word = pattern_word(TEST_PATTERN);
`endif

  train_word_checker #(
    .CHECK_LEN (CHECK_LEN)
  ) u_checker (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .words_i ({adc4_i, adc3_i, adc2_i, adc1_i}),
    .exp_i   (exp_word),
    .clr_i   (chk_clr),
    .pass_o  (pass)
  );

  always_comb begin
    state_d      = state_q;
    outtest_d    = outtest_q;
    tp_d         = tp_q;
    cfg_start_d  = 1'b0;
    bs_start_d   = 1'b0;
    busy_d       = busy_q;
    link_ok_d    = link_ok_q;
    fail_d       = fail_q;
    fail_code_d  = fail_code_q;
    retry_d      = retry_q;
    attempt_fail = 1'b0;
    go_fail      = 1'b0;
    fail_code_n  = FC_NONE;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          link_ok_d   = 1'b0;
          fail_d      = 1'b0;
          fail_code_d = FC_NONE;
          retry_d     = '0;
          busy_d      = 1'b1;
          state_d     = StCfgTp;
        end
      end
      StCfgTp: begin
        outtest_d   = 1'b1;
        tp_d        = TEST_PATTERN;
        cfg_start_d = 1'b1;
        state_d     = StWaitTp;
      end
      StWaitTp: begin
        // cfg_done takes priority over a coincident timeout.
        if (cfg_done_i) begin
          if (cfg_outtest_rdbk_i) begin
            state_d = StBitslip;
          end else begin
            go_fail     = 1'b1;
            fail_code_n = FC_RDBK;
          end
        end else if (timeout) begin
          go_fail     = 1'b1;
          fail_code_n = FC_CFG_TO;
        end
      end
      StBitslip: begin
        bs_start_d = 1'b1;
        state_d    = StWaitBs;
      end
      StWaitBs: begin
        if (bs_cmp_i && !bs_err_i) begin
          state_d = StCheck;
        end else if (bs_err_i || timeout) begin
          attempt_fail = 1'b1;
          fail_code_n  = FC_BITSLIP;
        end
      end
      StCheck: begin
        if (pass) begin
`ifdef TRAIN_ALTPAT_EN
          state_d = StCfgAlt;
`else
          state_d = StCfgNorm;
`endif
        end else if (timeout) begin
          attempt_fail = 1'b1;
          fail_code_n  = FC_PATTERN;
        end
      end
`ifdef TRAIN_ALTPAT_EN
      StCfgAlt: begin
        tp_d        = ~TEST_PATTERN;
        cfg_start_d = 1'b1;
        state_d     = StWaitAlt;
      end
      StWaitAlt: begin
        if (cfg_done_i) begin
          if (cfg_outtest_rdbk_i) begin
            state_d = StCheckAlt;
          end else begin
            go_fail     = 1'b1;
            fail_code_n = FC_RDBK;
          end
        end else if (timeout) begin
          go_fail     = 1'b1;
          fail_code_n = FC_CFG_TO;
        end
      end
      StCheckAlt: begin
        if (pass) begin
          state_d = StCfgNorm;
        end else if (timeout) begin
          go_fail     = 1'b1;
          fail_code_n = FC_PATTERN;
        end
      end
`endif
      StCfgNorm: begin
        outtest_d   = 1'b0;
        cfg_start_d = 1'b1;
        state_d     = StWaitNorm;
      end
      StWaitNorm: begin
        if (cfg_done_i) begin
          if (!cfg_outtest_rdbk_i) begin
            link_ok_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = StDone;
          end else begin
            go_fail     = 1'b1;
            fail_code_n = FC_RDBK;
          end
        end else if (timeout) begin
          go_fail     = 1'b1;
          fail_code_n = FC_CFG_TO;
        end
      end
      StDone, StFail: state_d = StIdle;
      default:        state_d = StIdle;
    endcase

    // Retry count saturates at the last attempt index.
    if (attempt_fail) begin
      if (retry_q < 2'(MAX_RETRY - 1)) begin
        retry_d = retry_q + 2'd1;
        state_d = StBitslip;
      end else begin
        go_fail = 1'b1;
      end
    end

    if (go_fail) begin
      state_d     = StFail;
      fail_d      = 1'b1;
      fail_code_d = fail_code_n;
      busy_d      = 1'b0;
      outtest_d   = 1'b0;
    end

    tmo_d = (state_d != state_q) ? '0 : tmo_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    // Tracked through reset so a start held across reset is not seen as an edge.
    start_q <= train_start_i;
    if (reset_i) begin
      state_q     <= StIdle;
      tmo_q       <= '0;
      outtest_q   <= 1'b0;
      tp_q        <= '0;
      cfg_start_q <= 1'b0;
      bs_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      link_ok_q   <= 1'b0;
      fail_q      <= 1'b0;
      fail_code_q <= FC_NONE;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      outtest_q   <= outtest_d;
      tp_q        <= tp_d;
      cfg_start_q <= cfg_start_d;
      bs_start_q  <= bs_start_d;
      busy_q      <= busy_d;
      link_ok_q   <= link_ok_d;
      fail_q      <= fail_d;
      fail_code_q <= fail_code_d;
      retry_q     <= retry_d;
    end
  end

  assign cfg_outtest_o     = outtest_q;
  assign cfg_testpattern_o = tp_q;
  assign cfg_start_o       = cfg_start_q;
  assign bs_start_o        = bs_start_q;
  assign busy_o            = busy_q;
  assign link_ok_o         = link_ok_q;
  assign fail_o            = fail_q;
  assign fail_code_o       = fail_code_q;
  assign retry_cnt_o       = retry_q;

endmodule

// File: tb/tb_ltc2174_train_ctrl.sv
// Randomized bench for ltc2174_train_ctrl; outcomes checked against a scenario-level model.
module tb_ltc2174_train_ctrl;

  localparam logic [13:0] TP        = 14'h2A5C;
  localparam logic [15:0] EXP_W     = 16'hA970;
  localparam int          CHECK_LEN = 64;
  localparam int          MAX_RETRY = 3;
  localparam int          TMO_W     = 10;
  localparam int          TMO       = (1 << TMO_W) - 1;

  typedef struct {
    bit       tp_to;
    bit       tp_rdbk;
    int       tp_dly;
    bit [2:0] att_good;
    bit [2:0] att_err;
    bit [2:0] att_to;
    int       bs_dly;
    bit       glitch;
    bit       norm_to;
    bit       norm_rdbk;
    int       norm_dly;
  } scen_t;

  typedef struct {
    int link_ok;
    int fail;
    int fc;
    int retry;
    int n_cfg;
    int n_bs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, train_start, cfg_done, cfg_rdbk, bs_cmp, bs_err;
  logic [15:0] adc [4];
  logic        cfg_outtest, cfg_start, bs_start, busy, link_ok, fail;
  logic [13:0] cfg_tp;
  logic [2:0]  fail_code;
  logic [1:0]  retry_cnt;

  int    n_checks = 0;
  int    n_errs = 0;
  int    cfg_pulses = 0;
  int    bs_pulses = 0;
  string cur = "init";

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_start) cfg_pulses++;
    if (bs_start) bs_pulses++;
  end

  ltc2174_train_ctrl #(
    .TEST_PATTERN (TP),
    .CHECK_LEN    (CHECK_LEN),
    .MAX_RETRY    (MAX_RETRY),
    .TIMEOUT_W    (TMO_W)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .train_start_i      (train_start),
    .cfg_outtest_o      (cfg_outtest),
    .cfg_testpattern_o  (cfg_tp),
    .cfg_start_o        (cfg_start),
    .cfg_done_i         (cfg_done),
    .cfg_outtest_rdbk_i (cfg_rdbk),
    .bs_start_o         (bs_start),
    .bs_cmp_i           (bs_cmp),
    .bs_err_i           (bs_err),
    .adc1_i             (adc[0]),
    .adc2_i             (adc[1]),
    .adc3_i             (adc[2]),
    .adc4_i             (adc[3]),
    .busy_o             (busy),
    .link_ok_o          (link_ok),
    .fail_o             (fail),
    .fail_code_o        (fail_code),
    .retry_cnt_o        (retry_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s/%s got %0h expected %0h", cur, tag, got, exp);
    end
  endtask

  // which: 0 cfg_start, 1 bs_start, 2 sequence finished
  task automatic wait_sig(input int which, input int bound, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      n = i + 1;
      if ((which == 0 && cfg_start) || (which == 1 && bs_start) ||
          (which == 2 && !busy && (link_ok || fail))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic recover();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_cfg_done(input bit rdbk);
    cfg_done = 1'b1;
    cfg_rdbk = rdbk;
    @(negedge clk);
    cfg_done = 1'b0;
    cfg_rdbk = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_words(input bit good);
    for (int i = 0; i < 4; i++) adc[i] = EXP_W;
    if (!good) adc[$urandom_range(0, 3)] = EXP_W ^ (16'h1 << $urandom_range(0, 15));
  endtask

  function automatic exp_t model(input scen_t s);
    exp_t e;
    e = '{link_ok: 0, fail: 0, fc: 0, retry: 0, n_cfg: 1, n_bs: 0};
    if (s.tp_to || !s.tp_rdbk) begin
      e.fail = 1;
      e.fc   = s.tp_to ? 1 : 2;
      return e;
    end
    for (int a = 0; a < MAX_RETRY; a++) begin
      e.n_bs++;
      if (s.att_good[a] && !s.att_err[a] && !s.att_to[a]) begin
        e.n_cfg = 2;
        if (s.norm_to)        begin e.fail = 1; e.fc = 1; end
        else if (s.norm_rdbk) begin e.fail = 1; e.fc = 2; end
        else                  e.link_ok = 1;
        return e;
      end
      if (a == MAX_RETRY - 1) begin
        e.fail = 1;
        e.fc   = (s.att_err[a] || s.att_to[a]) ? 3 : 4;
        return e;
      end
      e.retry = a + 1;
    end
    return e;
  endfunction

  function automatic scen_t nominal();
    scen_t s;
    s = '{tp_to: 0, tp_rdbk: 1, tp_dly: 40, att_good: 3'b111, att_err: 3'b000,
          att_to: 3'b000, bs_dly: 200, glitch: 0, norm_to: 0, norm_rdbk: 0, norm_dly: 40};
    return s;
  endfunction

  function automatic scen_t rand_scen();
    scen_t s;
    int    r;
    s = nominal();
    s.tp_to     = ($urandom_range(0, 9) == 0);
    s.tp_rdbk   = ($urandom_range(0, 9) != 0);
    s.tp_dly    = $urandom_range(1, 300);
    s.bs_dly    = $urandom_range(1, 300);
    s.norm_dly  = $urandom_range(1, 300);
    s.glitch    = ($urandom_range(0, 3) == 0);
    s.norm_to   = ($urandom_range(0, 9) == 0);
    s.norm_rdbk = ($urandom_range(0, 7) == 0);
    for (int a = 0; a < 3; a++) begin
      r = $urandom_range(0, 9);
      s.att_good[a] = (r < 5);
      s.att_err[a]  = (r == 7 || r == 8);
      s.att_to[a]   = (r == 9);
    end
    return s;
  endfunction

  task automatic run(input scen_t s, input string name);
    exp_t e;
    bit   ok, passed;
    int   n, c0, b0, elapsed, lo;
    cur = name;
    e = model(s);
    #1;
    c0 = cfg_pulses;
    b0 = bs_pulses;
    @(negedge clk);
    train_start = 1'b1;
    wait_sig(0, 10, ok, n);
    check_val("tp_cfg_start_seen", ok, 1);
    if (!ok) begin train_start = 1'b0; recover(); return; end
    check_val("start_latency", n, 2);
    check_val("tp_value", cfg_tp, TP);
    check_val("tp_outtest", cfg_outtest, 1);
    check_val("busy_running", busy, 1);
    train_start = 1'b0;
    // A second start edge while busy must not restart anything.
    @(negedge clk);
    train_start = 1'b1;
    @(negedge clk);
    train_start = 1'b0;
    passed = 1'b0;
    if (!s.tp_to) begin
      repeat (s.tp_dly) @(negedge clk);
      pulse_cfg_done(s.tp_rdbk);
      if (s.tp_rdbk) begin
        for (int a = 0; a < MAX_RETRY; a++) begin
          wait_sig(1, TMO + 20, ok, n);
          check_val("bs_start_seen", ok, 1);
          if (!ok) begin recover(); return; end
          drive_words(s.att_good[a]);
          repeat (s.bs_dly) @(negedge clk);
          if (s.att_err[a]) begin
            bs_err = 1'b1;
            bs_cmp = 1'($urandom_range(0, 1));
            @(negedge clk);
            bs_err = 1'b0;
            bs_cmp = 1'b0;
          end else if (!s.att_to[a]) begin
            bs_cmp = 1'b1;
            @(negedge clk);
            bs_cmp = 1'b0;
          end
          if (s.att_good[a] && !s.att_err[a] && !s.att_to[a]) begin
            passed = 1'b1;
            break;
          end
        end
      end
    end
    if (passed) begin
      elapsed = 0;
      if (s.glitch) begin
        repeat (63) @(negedge clk);
        adc[2] = EXP_W ^ 16'h0004;
        @(negedge clk);
        adc[2] = EXP_W;
        elapsed = 64;
      end
      wait_sig(0, CHECK_LEN * 3, ok, n);
      check_val("norm_cfg_start_seen", ok, 1);
      if (!ok) begin recover(); return; end
      elapsed += n;
      lo = s.glitch ? 2 * CHECK_LEN : CHECK_LEN;
      check_val("check_duration", (elapsed >= lo) && (elapsed <= lo + 4), 1);
      check_val("norm_outtest", cfg_outtest, 0);
      if (!s.norm_to) begin
        repeat (s.norm_dly) @(negedge clk);
        pulse_cfg_done(s.norm_rdbk);
      end
    end
    wait_sig(2, TMO + 40, ok, n);
    check_val("finished", ok, 1);
    if (!ok) begin recover(); return; end
    check_val("link_ok", link_ok, e.link_ok);
    check_val("fail", fail, e.fail);
    check_val("fail_code", fail_code, e.fc);
    check_val("retry_cnt", retry_cnt, e.retry);
    check_val("end_outtest", cfg_outtest, 0);
    repeat (3) @(negedge clk);
    #1;
    check_val("sticky_link_ok", link_ok, e.link_ok);
    check_val("cfg_pulses", cfg_pulses - c0, e.n_cfg);
    check_val("bs_pulses", bs_pulses - b0, e.n_bs);
  endtask

  task automatic check_reset_outputs();
    check_val("rst_outtest", cfg_outtest, 0);
    check_val("rst_tp", cfg_tp, 0);
    check_val("rst_cfg_start", cfg_start, 0);
    check_val("rst_bs_start", bs_start, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_link_ok", link_ok, 0);
    check_val("rst_fail", fail, 0);
    check_val("rst_fail_code", fail_code, 0);
    check_val("rst_retry", retry_cnt, 0);
  endtask

  initial begin
    scen_t s;
    bit    ok;
    int    n, c0, b0;
    reset       = 1'b1;
    train_start = 1'b0;
    cfg_done    = 1'b0;
    cfg_rdbk    = 1'b0;
    bs_cmp      = 1'b0;
    bs_err      = 1'b0;
    for (int i = 0; i < 4; i++) adc[i] = 16'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clk);

    run(nominal(), "nominal");
    s = nominal(); s.glitch = 1'b1;
    run(s, "glitch");
    s = nominal(); s.att_good = 3'b000;
    run(s, "retries");
    s = nominal(); s.att_err = 3'b001;
    run(s, "bs_err_first");
    s = nominal(); s.tp_to = 1'b1;
    run(s, "cfg_timeout");
    s = nominal(); s.tp_rdbk = 1'b0;
    run(s, "tp_rdbk_bad");

    // Reset while waiting for bitslip completion.
    cur = "reset_wait_bs";
    @(negedge clk);
    train_start = 1'b1;
    wait_sig(0, 10, ok, n);
    check_val("cfg_start_seen", ok, 1);
    train_start = 1'b0;
    pulse_cfg_done(1'b1);
    wait_sig(1, 20, ok, n);
    check_val("bs_start_seen", ok, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs();
    #1;
    c0 = cfg_pulses;
    b0 = bs_pulses;
    bs_cmp = 1'b1;
    @(negedge clk);
    bs_cmp = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check_val("no_cfg_after_reset", cfg_pulses - c0, 0);
    check_val("no_bs_after_reset", bs_pulses - b0, 0);
    check_val("idle_after_reset", busy, 0);
    run(nominal(), "after_reset");

    for (int i = 0; i < 10; i++) run(rand_scen(), $sformatf("rand%0d", i));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/ltc2174_train_ctrl.md
Name: ltc2174_train_ctrl

Overview:
Link-training sequencer for one LTC2174 bank. It programs the ADC test pattern through the bank's SPI config request path, then launches bitslip alignment. It checks all four channel words against the expected pattern and restores normal output mode. It sits beside ltc2174_onebank and drives its testpattern/outtest/spi_start/bitslip_start controls, reporting link_ok or a failure code to software.

Parameters:
TEST_PATTERN, 14'h2A5C, pattern programmed during training
CHECK_LEN, 64, consecutive matching clk cycles required for pass
MAX_RETRY, 3, bitslip+check attempts before FAIL
TIMEOUT_W, 16, width of per-wait timeout counter; timeout = 2^TIMEOUT_W-1 cycles

Ports:
clk  in  1  single clock; all inputs synchronous to it
reset  in  1  synchronous, active-high
train_start  in  1  rising edge starts training
cfg_outtest  out  1  outtest value presented to SPI config
cfg_testpattern  out  14  testpattern value presented to SPI config
cfg_start  out  1  one-cycle pulse requesting a full SPI write+readback
cfg_done  in  1  one-cycle pulse: SPI sequence complete
cfg_outtest_rdbk  in  1  readback of outtest
bs_start  out  1  one-cycle bitslip_start pulse
bs_cmp  in  1  bitslip search complete
bs_err  in  1  bitslip search error
adc1, adc2, adc3, adc4  in  16 each  deserialized channel words
busy  out  1  high from accepted start until DONE/FAIL
link_ok  out  1  sticky pass flag
fail  out  1  sticky fail flag
fail_code  out  3  0 none, 1 cfg timeout, 2 readback mismatch, 3 bitslip err/timeout, 4 pattern mismatch after MAX_RETRY
retry_cnt  out  2  attempts used

Behaviour:
- Reset: state IDLE; cfg_outtest=0, cfg_testpattern=0, cfg_start=0, bs_start=0, busy=0, link_ok=0, fail=0, fail_code=0, retry_cnt=0. Reset mid-sequence aborts immediately with the same values. No SPI request is issued on reset.
- Expected word: EXP = {TEST_PATTERN,2'b00}, compared on all four channels.
- IDLE: on train_start rising edge, clear link_ok/fail/fail_code/retry_cnt, set busy and enter CFG_TP. Start edges while busy are ignored.
- CFG_TP: drive cfg_outtest=1, cfg_testpattern=TEST_PATTERN, pulse cfg_start for 1 cycle, then enter WAIT_TP.
- WAIT_TP: on cfg_done, go to BITSLIP if cfg_outtest_rdbk=1, else FAIL with code 2. Timeout gives FAIL code 1.
- BITSLIP: pulse bs_start for 1 cycle, then enter WAIT_BS.
- WAIT_BS: bs_cmp&~bs_err goes to CHECK. bs_err, or timeout, counts as a failed attempt.
- CHECK: match counter counts cycles where all four words equal EXP and resets to 0 on any mismatch. Reaching CHECK_LEN goes to CFG_NORM. Timeout counts as a failed attempt.
- Failed attempt: retry_cnt+1. If retry_cnt < MAX_RETRY-1, return to BITSLIP. Else FAIL with code 4 (from CHECK) or 3 (from WAIT_BS). retry_cnt saturates.
- CFG_NORM/WAIT_NORM: cfg_outtest=0, pulse cfg_start, wait cfg_done. Require rdbk=0, else code 2. Timeout gives code 1. On success, enter DONE.
- DONE: link_ok=1, busy=0, then return to IDLE. link_ok holds until the next start or reset.
- FAIL: fail=1, busy=0, cfg_outtest forced 0 without issuing SPI, then return to IDLE.
- The timeout counter clears on every state entry. If cfg_done and timeout occur in the same cycle, cfg_done wins.
- Pulses are exactly one cycle. Latency from start to the first cfg_start is 2 cycles.

Optional Feature:
TRAIN_ALTPAT_EN
- Defined: after the first CHECK passes, the block reprograms cfg_testpattern=~TEST_PATTERN (CFG_ALT/WAIT_ALT), then runs a second CHECK against {~TEST_PATTERN,2'b00} with no bitslip. A failure there is code 4 with no retry.
- Undefined: CHECK goes directly to CFG_NORM.

Decomposition:
- Package ltc2174_train_pkg holds:
  - state encoding constants
  - fail_code constants (FC_NONE, FC_CFG_TO, FC_RDBK, FC_BITSLIP, FC_PATTERN)
  - default TEST_PATTERN
- One sub-module, train_word_checker: 4-channel comparator plus consecutive-match counter, with inputs words, exp, clr and output pass.

Test Plan:
- Nominal: start, cfg_done after 40 cycles with rdbk=1, bs_cmp after 200 cycles, words=16'hA970 for 64 cycles, final cfg_done with rdbk=0 -> link_ok=1, fail_code=0, exactly 2 cfg_start and 1 bs_start pulses.
- Glitchy check: adc3 mismatches at match count 63 -> counter restarts, pass after 64 further clean cycles, retry_cnt=0.
- Retries: words never match -> 3 bs_start pulses, then fail=1, fail_code=4, retry_cnt=2, cfg_outtest=0.
- Bitslip error: bs_err on first attempt, clean second attempt -> link_ok=1, retry_cnt=1.
- Config failure: no cfg_done -> fail_code=1 after 65535 cycles. cfg_done with rdbk=0 in WAIT_TP -> fail_code=2 immediately.
- Reset during WAIT_BS: all outputs return to reset values next cycle, no further pulses, and a new start trains normally.
